// File: rtl/breath_controller.sv
// LED breathing/animation brightness controller with registered color select.
// Optional: define BREATH_GAMMA_EN for a squared (gamma) brightness output stage.
module breath_controller #(
  parameter int          BRT_W   = 5,
  parameter int          DIV_MAX = 1023,
  parameter logic [23:0] COLOR0  = 24'h7F1FFF,
  parameter logic [23:0] COLOR1  = 24'h00FFFF,
  parameter logic [23:0] COLOR2  = 24'hFFFF00,
  parameter logic [23:0] COLOR3  = 24'hFF00FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [1:0]       sw,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [23:0]      color,
  output logic [BRT_W-1:0] brightness,
  output logic             peak,
  output logic             trough
);

  typedef enum logic {PH_UP = 1'b0, PH_DOWN = 1'b1} phase_e;
  typedef enum logic [1:0] {
    M_BREATHE = 2'b00,
    M_SAW     = 2'b01,
    M_STEADY  = 2'b10,
    M_BLINK   = 2'b11
  } mode_e;

  localparam logic [BRT_W-1:0] MAX     = {BRT_W{1'b1}};
  localparam logic [BRT_W-1:0] ONE     = BRT_W'(1);
  localparam logic [15:0]      DIV_END = 16'(DIV_MAX);

  logic [23:0]      color_q, color_d;
  logic [15:0]      div_q, div_d;
  logic [BRT_W-1:0] br_q, br_d;
  phase_e           phase_q, phase_d;
  mode_e            mode_q, mode_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;
  logic             step;
  logic             mode_chg;

  assign step     = tick & ~hold & (div_q == DIV_END);
  assign mode_chg = (mode != mode_q);

  always_comb begin
    case (sw)
      2'd0:    color_d = COLOR0;
      2'd1:    color_d = COLOR1;
      2'd2:    color_d = COLOR2;
      default: color_d = COLOR3;
    endcase
  end

  // A mode change restarts the animation and swallows any step landing on the same clk.
  always_comb begin
    div_d    = div_q;
    br_d     = br_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    if (mode_chg) begin
      div_d   = '0;
      br_d    = '0;
      phase_d = PH_UP;
      mode_d  = mode_e'(mode);
    end else begin
      if (tick && !hold) begin
        div_d = (div_q == DIV_END) ? 16'd0 : div_q + 16'd1;
      end
      case (mode_q)
        M_BREATHE: begin
          if (step) begin
            if (phase_q == PH_UP) begin
              if (br_q == MAX) begin
                br_d    = MAX - ONE;
                phase_d = PH_DOWN;
              end else begin
                br_d = br_q + ONE;
              end
            end else begin
              if (br_q == '0) begin
                br_d    = ONE;
                phase_d = PH_UP;
              end else begin
                br_d = br_q - ONE;
              end
            end
            peak_d   = (br_d == MAX);
            trough_d = (br_d == '0);
          end
        end
        M_SAW: begin
          if (step) begin
            br_d    = (br_q == MAX) ? '0 : br_q + ONE;
            phase_d = PH_UP;
            peak_d  = (br_d == MAX);
          end
        end
        M_STEADY: begin
          br_d = MAX;
        end
        M_BLINK: begin
          if (step) begin
            br_d   = (br_q == '0) ? MAX : '0;
            peak_d = (br_d == MAX);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color_q  <= COLOR0;
      div_q    <= '0;
      br_q     <= '0;
      phase_q  <= PH_UP;
      mode_q   <= M_BREATHE;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
    end else begin
      color_q  <= color_d;
      div_q    <= div_d;
      br_q     <= br_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
    end
  end

  assign color = color_q;

`ifdef BREATH_GAMMA_EN
  logic [2*BRT_W-1:0] sq;
  logic [BRT_W-1:0]   gamma_q;
  logic               peak_dly_q;
  logic               trough_dly_q;

  assign sq = {{BRT_W{1'b0}}, br_q} * {{BRT_W{1'b0}}, br_q};

  // Pulses ride one extra stage so they line up with the squared brightness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gamma_q      <= '0;
      peak_dly_q   <= 1'b0;
      trough_dly_q <= 1'b0;
    end else begin
      gamma_q      <= sq[2*BRT_W-1:BRT_W];
      peak_dly_q   <= peak_q;
      trough_dly_q <= trough_q;
    end
  end

  assign brightness = gamma_q;
  assign peak       = peak_dly_q;
  assign trough     = trough_dly_q;
`else
  assign brightness = br_q;
  assign peak       = peak_q;
  assign trough     = trough_q;
`endif

endmodule

// File: tb/tb_breath_controller.sv
// Self-checking bench for breath_controller: vector table, directed corner cases,
// and randomized traffic against a step-position reference model.
module tb_breath_controller;

  localparam int BW   = 3;
  localparam int DM   = 3;
  localparam int MAXV = 7;

  logic        clk = 1'b0;
  logic        rst_n, tick, hold;
  logic [1:0]  sw, mode;
  logic [23:0] color;
  logic [BW-1:0] brightness;
  logic        peak, trough;

  always #5 clk = ~clk;

  breath_controller #(.BRT_W(BW), .DIV_MAX(DM)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sw(sw), .mode(mode), .hold(hold),
    .color(color), .brightness(brightness), .peak(peak), .trough(trough)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: animation position counted in steps within each mode's period.
  logic [1:0]  mMode;
  int          mCnt, mStep, linBr, outBr;
  bit          linPk, linTr, outPk, outTr;
  logic [23:0] mColor;

  function automatic logic [23:0] colorOf(input logic [1:0] s);
    case (s)
      2'd0:    return 24'h7F1FFF;
      2'd1:    return 24'h00FFFF;
      2'd2:    return 24'hFFFF00;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic int periodOf(input logic [1:0] m);
    case (m)
      2'd0:    return 2 * MAXV;
      2'd1:    return MAXV + 1;
      2'd2:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int levelOf(input logic [1:0] m, input int s);
    case (m)
      2'd0:    return (s <= MAXV) ? s : 2 * MAXV - s;
      2'd1:    return s;
      2'd2:    return MAXV;
      default: return (s % 2 == 1) ? MAXV : 0;
    endcase
  endfunction

  task automatic modelEdge();
    bit stepped;
    stepped = 1'b0;
    if (!rst_n) begin
      mMode = 2'd0; mCnt = 0; mStep = 0; mColor = colorOf(2'd0);
      linBr = 0; linPk = 1'b0; linTr = 1'b0;
      outBr = 0; outPk = 1'b0; outTr = 1'b0;
    end else begin
`ifdef BREATH_GAMMA_EN
      outBr = (linBr * linBr) >> BW;
      outPk = linPk;
      outTr = linTr;
`endif
      mColor = colorOf(sw);
      if (mode != mMode) begin
        mMode = mode; mCnt = 0; mStep = 0;
        linBr = 0; linPk = 1'b0; linTr = 1'b0;
      end else begin
        if (tick && !hold) begin
          if (mCnt == DM) begin
            mCnt = 0;
            mStep = (mStep + 1) % periodOf(mMode);
            stepped = 1'b1;
          end else begin
            mCnt++;
          end
        end
        linBr = levelOf(mMode, mStep);
        linPk = stepped && (mMode != 2'd2) && (linBr == MAXV);
        linTr = stepped && (mMode == 2'd0) && (linBr == 0);
      end
`ifndef BREATH_GAMMA_EN
      outBr = linBr;
      outPk = linPk;
      outTr = linTr;
`endif
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " brightness"}, 32'(brightness), 32'(outBr));
    check({tag, " peak"}, 32'(peak), 32'(outPk));
    check({tag, " trough"}, 32'(trough), 32'(outTr));
    check({tag, " color"}, 32'(color), 32'(mColor));
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [1:0] s,
                               input logic [1:0] m, input logic h, input string tag);
    rst_n = r; tick = t; sw = s; mode = m; hold = h;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  // Runs breathe with a tick every clk until the model sits at a fresh step position.
  task automatic runToStep(input int target, input string tag);
    int i;
    bit reached;
    i = 0;
    reached = (mMode == 2'd0) && (mStep == target) && (mCnt == 0);
    while (!reached && i < 400) begin
      applyStimulus(1'b1, 1'b1, sw, 2'd0, 1'b0, tag);
      reached = (mMode == 2'd0) && (mStep == target) && (mCnt == 0);
      i++;
    end
    check({tag, " reached"}, 32'(reached), 32'd1);
  endtask

  typedef struct {
    logic        rstN;
    logic        tick;
    logic [1:0]  sw;
    logic [1:0]  mode;
    logic        hold;
    logic [2:0]  expBr;
    logic        expPeak;
    logic        expTrough;
    logic [23:0] expColor;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst_n = 1'b0; tick = 1'b0; sw = 2'd0; mode = 2'd0; hold = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 24'h7F1FFF};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 24'hFFFF00};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 24'hFFFF00};
    vecs[3]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 24'hFFFF00};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0, 24'hFFFF00};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0, 24'h00FFFF};

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rstN, vecs[v].tick, vecs[v].sw, vecs[v].mode, vecs[v].hold,
                    $sformatf("vec%0d", v));
`ifndef BREATH_GAMMA_EN
      check($sformatf("vec%0d table brightness", v), 32'(brightness), 32'(vecs[v].expBr));
      check($sformatf("vec%0d table peak", v), 32'(peak), 32'(vecs[v].expPeak));
      check($sformatf("vec%0d table trough", v), 32'(trough), 32'(vecs[v].expTrough));
`endif
      check($sformatf("vec%0d table color", v), 32'(color), 32'(vecs[v].expColor));
    end

    // Full breathe period and beyond, then a full sawtooth run.
    for (int i = 0; i < 4 * 2 * MAXV + 8; i++) applyStimulus(1'b1, 1'b1, 2'd3, 2'd0, 1'b0, "breathe");
    for (int i = 0; i < 4 * (MAXV + 1) * 2 + 4; i++) applyStimulus(1'b1, 1'b1, 2'd3, 2'd1, 1'b0, "saw");

    // Mid-ramp switch to blink at brightness 5.
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, "toBreathe");
    runToStep(5, "ramp5");
`ifndef BREATH_GAMMA_EN
    check("ramp5 level", 32'(brightness), 32'd5);
`endif
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd3, 1'b0, "blinkEntry");
    check("blinkEntry zero", 32'(brightness), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'd0, 2'd3, 1'b0, "blinkOn");
`ifndef BREATH_GAMMA_EN
    check("blinkOn level", 32'(brightness), 32'd7);
    check("blinkOn peak", 32'(peak), 32'd1);
`endif
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 2'd0, 2'd3, 1'b0, "blinkRun");

    // Steady entry: zero on the change clk, MAX afterwards.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 2'd1, 2'd2, 1'b0, "steady");

    // Hold for ten ticks at brightness 3.
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, "toBreathe2");
    runToStep(3, "ramp3");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, "hold");
`ifndef BREATH_GAMMA_EN
      check("hold frozen", 32'(brightness), 32'd3);
`endif
      check("hold no peak", 32'(peak), 32'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, "release");
`ifndef BREATH_GAMMA_EN
    check("release resumes", 32'(brightness), 32'd4);
`endif

    // Reset in the falling half at brightness 6 with sw=2.
    runToStep(8, "down6");
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd0, 1'b0, "rstPulse");
    check("rstPulse brightness", 32'(brightness), 32'd0);
    check("rstPulse color", 32'(color), 32'h7F1FFF);
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, "rstRelease");
    check("rstRelease color", 32'(color), 32'hFFFF00);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      logic r, t, h;
      logic [1:0] s, m;
      r = ($urandom_range(0, 299) != 0);
      t = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : sw;
      m = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(0, 3)) : mode;
      applyStimulus(r, t, s, m, h, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/breath_controller.md
BREATH_CONTROLLER -- requirements
Module: breath_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  BRT_W  5  brightness width; MAX = 2^BRT_W-1
  DIV_MAX  1023  tick prescale terminal count; step period = DIV_MAX+1 ticks; range 0..65535
  COLOR0  24'h7F1FFF  color for sel 0
  COLOR1  24'h00FFFF  color for sel 1
  COLOR2  24'hFFFF00  color for sel 2
  COLOR3  24'hFF00FF  color for sel 3
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous reset, active-low
  tick  in  1  single-cycle time-base enable
  sw  in  2  color select
  mode  in  2  00 breathe, 01 sawtooth, 10 steady, 11 blink
  hold  in  1  freeze animation
  color  out  24  selected color
  brightness  out  BRT_W  current brightness
  peak  out  1  one-clk pulse when brightness becomes MAX
  trough  out  1  one-clk pulse when brightness becomes 0 in breathe mode
REQ-003 Reset SHALL be synchronous active-low on rst_n; all state SHALL be in the clk domain.

Function
REQ-004 color SHALL be registered: COLORn for sw=n, one clk after sw changes.
REQ-005 div_cnt (16 bits) SHALL increment on each clk with tick=1 and hold=0, wrapping DIV_MAX->0; step = tick & ~hold & (div_cnt==DIV_MAX).
REQ-006 A registered copy mode_q SHALL track mode; when mode!=mode_q, the next clk SHALL set div_cnt=0, brightness=0, phase=UP, mode_q=mode, with no step in that clk.
REQ-007 Mode change SHALL take priority over a simultaneous step; hold SHALL take priority over tick.
REQ-008 Breathe: phase UP/DOWN; on step in UP: br==MAX -> br=MAX-1, phase=DOWN; else br+1. In DOWN: br==0 -> br=1, phase=UP; else br-1.
REQ-009 Sawtooth: on step br==MAX -> br=0, else br+1; phase stays UP.
REQ-010 Steady: brightness SHALL read MAX from the clk after entry; steps SHALL have no effect.
REQ-011 Blink: on step br toggles between 0 and MAX.
REQ-012 peak SHALL pulse in the clk brightness is updated to MAX by a step (all modes except steady); trough SHALL pulse when breathe updates brightness to 0.
REQ-013 peak and trough SHALL be 0 whenever hold=1 or during a mode-change clk.
REQ-014 Brightness arithmetic SHALL be BRT_W bits, never overflowing past MAX or underflowing below 0.

Reset
REQ-015 rst_n=0 at a clk edge SHALL set color=COLOR0, brightness=0, peak=0, trough=0, div_cnt=0, phase=UP, mode_q=00, regardless of operation in progress.
REQ-016 Reset SHALL take priority over mode change, hold and step.

Configuration
REQ-017 With BREATH_GAMMA_EN defined, brightness SHALL be (br*br)>>BRT_W, registered, one extra clk latency, with peak/trough delayed to stay aligned; MAX maps to MAX-1 floor value as computed.
REQ-018 Without BREATH_GAMMA_EN, brightness SHALL equal the linear counter directly, with no extra latency.

Verification
REQ-019 BRT_W=3, DIV_MAX=3, mode=00, tick every clk: brightness sequence 0,1..7,6..0,1 with one change per 4 ticks; peak on 7, trough on 0.
REQ-020 mode=01, same params: 0..7,0 wrap; peak at each 7; trough never asserts.
REQ-021 Mid-ramp at br=5, set mode=11: next clk br=0, div_cnt=0; then toggles 7,0,7 every 4 ticks.
REQ-022 hold=1 for 10 ticks at br=3: brightness and div_cnt unchanged, no pulses; resumes from 3 after release.
REQ-023 Assert rst_n=0 for one clk at br=6 DOWN with sw=2: next clk br=0, color=24'h7F1FFF, then color=24'hFFFF00 one clk after release.
REQ-024 With BREATH_GAMMA_EN, BRT_W=3: br=7 -> brightness 6, br=4 -> 2, output one clk behind linear counter.
